// File: rtl/cache_pkg.sv
// Shared types and constant helpers for the set-associative write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, UNCACHED, RESP} state_t;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int unsigned log2u(input int unsigned x);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(x)) r = i + 1;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned safe_w(input int unsigned x);
    return (log2u(x) == 0) ? 1 : log2u(x);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/cache_set_victim.sv
// Per-set tag compare across all ways, invalid-way priority pick and round-robin pointer step.
module cache_set_victim
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned TAG_W = 23,
  parameter int unsigned WAY_W = 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [TAG_W-1:0] tags [WAYS],
  input  logic [TAG_W-1:0] tag,
  input  logic [WAY_W-1:0] ptr,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_from_ptr,
  output logic [WAY_W-1:0] ptr_next
);

  always_comb begin
    hit             = 1'b0;
    hit_way         = '0;
    victim_way      = ptr;
    victim_from_ptr = 1'b1;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid[w] && (tags[w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim_way      = WAY_W'(w);
        victim_from_ptr = 1'b0;
      end
    end
    ptr_next = (WAYS > 1) ? ptr + WAY_W'(1) : '0;
  end

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back/write-allocate cache with an uncached MMIO window.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_assoc_wb
  import cache_pkg::*;
#(
  parameter int unsigned CACHE_BYTES   = 1024,
  parameter int unsigned BLOCK_BYTES   = 8,
  parameter int unsigned WAYS          = 2,
  parameter logic [31:0] UNCACHED_BASE = 32'h1000_0000,
  parameter logic [31:0] UNCACHED_MASK = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned WORDS  = BLOCK_BYTES / 4;
  localparam int unsigned SETS   = CACHE_BYTES / (BLOCK_BYTES * WAYS);
  localparam int unsigned OFF_W  = log2u(BLOCK_BYTES);
  localparam int unsigned IDX_W  = log2u(SETS);
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
  localparam int unsigned WAY_W  = safe_w(WAYS);
  localparam int unsigned BEAT_W = safe_w(WORDS);

  state_t             state_q;
  logic [31:2]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        data_q  [SETS][WAYS][WORDS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];
  logic [WAY_W-1:0]   vptr_q  [SETS];
  logic [WAY_W-1:0]   vway_q;
  logic [TAG_W-1:0]   vtag_q;
  logic               vuse_ptr_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               refill_q;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   req_tag;
  logic [BEAT_W-1:0]  wsel;
  logic [31:0]        beat_off;
  logic               beat_last;
  logic               in_window;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim_way;
  logic               victim_from_ptr;
  logic [WAY_W-1:0]   ptr_next;
  logic               addr_lsb_unused;

  assign idx             = addr_q[OFF_W +: IDX_W];
  assign req_tag         = addr_q[31 -: TAG_W];
  assign wsel            = (WORDS > 1) ? addr_q[2 +: BEAT_W] : '0;
  assign beat_off        = 32'(beat_q) << 2;
  assign beat_last       = (beat_q == BEAT_W'(WORDS - 1));
  assign in_window       = ((cpu_addr & UNCACHED_MASK) == UNCACHED_BASE);
  assign addr_lsb_unused = ^cpu_addr[1:0];

  cache_set_victim #(
    .WAYS (WAYS),
    .TAG_W(TAG_W),
    .WAY_W(WAY_W)
  ) u_victim (
    .valid          (valid_q[idx]),
    .tags           (tag_q[idx]),
    .tag            (req_tag),
    .ptr            (vptr_q[idx]),
    .hit            (hit),
    .hit_way        (hit_way),
    .victim_way     (victim_way),
    .victim_from_ptr(victim_from_ptr),
    .ptr_next       (ptr_next)
  );

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;
  assign hit_count  = hits_q;
  assign miss_count = misses_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  // Main controller; data/tag arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      valid_q    <= '{default: '0};
      dirty_q    <= '{default: '0};
      vptr_q     <= '{default: '0};
      vway_q     <= '0;
      vtag_q     <= '0;
      vuse_ptr_q <= 1'b0;
      beat_q     <= '0;
      refill_q   <= 1'b0;
`ifdef CACHE_STATS_EN
      hits_q     <= '0;
      misses_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cpu_valid) begin
          addr_q  <= cpu_addr[31:2];
          wdata_q <= cpu_wdata;
          wstrb_q <= cpu_wstrb;
          state_q <= in_window ? UNCACHED : LOOKUP;
        end
        LOOKUP: if (hit) begin
          if (wstrb_q != 4'h0) begin
            data_q[idx][hit_way][wsel] <= merge_bytes(data_q[idx][hit_way][wsel], wdata_q, wstrb_q);
            dirty_q[idx][hit_way]      <= 1'b1;
          end
          cpu_rdata <= data_q[idx][hit_way][wsel];
          cpu_ready <= 1'b1;
          refill_q  <= 1'b0;
          state_q   <= RESP;
`ifdef CACHE_STATS_EN
          if (!refill_q) hits_q <= hits_q + 32'd1;
`endif
        end else begin
          vway_q     <= victim_way;
          vtag_q     <= tag_q[idx][victim_way];
          vuse_ptr_q <= victim_from_ptr;
          beat_q     <= '0;
          state_q    <= (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) ? WB : FILL;
`ifdef CACHE_STATS_EN
          misses_q   <= misses_q + 32'd1;
`endif
        end
        WB: if (!mem_valid) begin
          mem_valid <= 1'b1;
          mem_addr  <= {vtag_q, idx, OFF_W'(0)} | beat_off;
          mem_wdata <= data_q[idx][vway_q][beat_q];
          mem_wstrb <= 4'hF;
        end else if (mem_ready) begin
          mem_valid <= 1'b0;
          beat_q    <= beat_last ? '0 : beat_q + BEAT_W'(1);
          if (beat_last) state_q <= FILL;
        end
        FILL: if (!mem_valid) begin
          mem_valid <= 1'b1;
          mem_addr  <= {req_tag, idx, OFF_W'(0)} | beat_off;
          mem_wdata <= '0;
          mem_wstrb <= 4'h0;
        end else if (mem_ready) begin
          mem_valid                    <= 1'b0;
          data_q[idx][vway_q][beat_q] <= mem_rdata;
          beat_q                       <= beat_last ? '0 : beat_q + BEAT_W'(1);
          if (beat_last) begin
            valid_q[idx][vway_q] <= 1'b1;
            dirty_q[idx][vway_q] <= 1'b0;
            tag_q[idx][vway_q]   <= req_tag;
            if (vuse_ptr_q) vptr_q[idx] <= ptr_next;
            refill_q             <= 1'b1;
            state_q              <= LOOKUP;
          end
        end
        UNCACHED: if (!mem_valid) begin
          mem_valid <= 1'b1;
          mem_addr  <= {addr_q, 2'b00};
          mem_wdata <= wdata_q;
          mem_wstrb <= wstrb_q;
        end else if (mem_ready) begin
          mem_valid <= 1'b0;
          cpu_rdata <= mem_rdata;
          cpu_ready <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          cpu_ready <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed self-checking bench for cache_assoc_wb with a fixed-latency beat memory model.
module tb_cache_assoc_wb;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] la [0:255];
  logic [31:0] lw [0:255];
  logic [3:0]  ls [0:255];
  int          beat_total = 0;
  int          dly = 0;

  always #5 clk = ~clk;

  cache_assoc_wb dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  // Memory model: delay counter restarts whenever valid is low.
  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (!mem_valid) begin
      dly <= 0;
    end else if (!mem_ready) begin
      if (dly == LAT) begin
        mem_ready <= 1'b1;
        dly       <= 0;
        la[beat_total[7:0]] <= mem_addr;
        lw[beat_total[7:0]] <= mem_wdata;
        ls[beat_total[7:0]] <= mem_wstrb;
        beat_total <= beat_total + 1;
        if (mem_addr[31:28] == 4'h0) begin
          mem_rdata <= mem[mem_addr[11:2]];
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
          mem_rdata <= 32'hDEAD_BEEF;
        end
      end else begin
        dly <= dly + 1;
      end
    end
  end

  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic cpu_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            output logic [31:0] rd, output int lat, output int base);
    @(negedge clk);
    base      = beat_total;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_wstrb = ws;
    cpu_valid = 1'b1;
    lat       = 0;
    rd        = 'x;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ready) begin
        rd = cpu_rdata;
        break;
      end
    end
    if (!cpu_ready) begin
      checks++; failures++;
      $display("FAIL cpu_timeout addr=%h: no cpu_ready within 300 cycles", a);
    end
    @(negedge clk);
    cpu_valid = 1'b0;
    cpu_wstrb = 4'h0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL reset_cpu_ready got=%b exp=0", cpu_ready); end
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_cpu_rdata got=%h exp=0", cpu_rdata); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_cold_read();
    logic [31:0] rd; int lat, base;
    cpu_access(32'h100, 32'h0, 4'h0, rd, lat, base);
    checks++; if (beat_total - base !== 2) begin failures++; $display("FAIL cold_beats got=%0d exp=2", beat_total - base); end
    checks++; if (la[base[7:0]] !== 32'h100 || ls[base[7:0]] !== 4'h0) begin
      failures++; $display("FAIL cold_beat0 got=%h/%h exp=00000100/0", la[base[7:0]], ls[base[7:0]]); end
    checks++; if (la[8'(base + 1)] !== 32'h104) begin failures++; $display("FAIL cold_beat1 got=%h exp=00000104", la[8'(base + 1)]); end
    checks++; if (rd !== 32'hAAAA0000) begin failures++; $display("FAIL cold_rdata got=%h exp=aaaa0000", rd); end
    checks++; if (miss_count !== st(1)) begin failures++; $display("FAIL cold_miss got=%0d exp=%0d", miss_count, st(1)); end
    cpu_access(32'h104, 32'h0, 4'h0, rd, lat, base);
    checks++; if (lat !== 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    checks++; if (beat_total - base !== 0) begin failures++; $display("FAIL hit_beats got=%0d exp=0", beat_total - base); end
    checks++; if (rd !== 32'hBBBB0001) begin failures++; $display("FAIL hit_rdata got=%h exp=bbbb0001", rd); end
    checks++; if (hit_count !== st(1)) begin failures++; $display("FAIL hit_count got=%0d exp=%0d", hit_count, st(1)); end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; int lat, base;
    cpu_access(32'h108, 32'h0, 4'h0, rd, lat, base);
    checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL bw_prefill got=%h exp=11223344", rd); end
    cpu_access(32'h108, 32'h0000_00EE, 4'b0001, rd, lat, base);
    checks++; if (beat_total - base !== 0 || lat !== 2) begin
      failures++; $display("FAIL bw_write beats=%0d lat=%0d exp=0/2", beat_total - base, lat); end
    cpu_access(32'h108, 32'h0, 4'h0, rd, lat, base);
    checks++; if (rd !== 32'h112233EE) begin failures++; $display("FAIL bw_merge got=%h exp=112233ee", rd); end
    checks++; if (beat_total - base !== 0) begin failures++; $display("FAIL bw_read_beats got=%0d exp=0", beat_total - base); end
    checks++; if (hit_count !== st(3) || miss_count !== st(2)) begin
      failures++; $display("FAIL bw_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, st(3), st(2)); end
  endtask

  task automatic test_eviction();
    logic [31:0] rd; int lat, base;
    cpu_access(32'h000, 32'h5, 4'hF, rd, lat, base);
    cpu_access(32'h200, 32'h0, 4'h0, rd, lat, base);
    checks++; if (beat_total - base !== 2 || la[base[7:0]] !== 32'h200) begin
      failures++; $display("FAIL ev_fill_way1 beats=%0d addr=%h exp=2/00000200", beat_total - base, la[base[7:0]]); end
    cpu_access(32'h400, 32'h0, 4'h0, rd, lat, base);
    checks++; if (beat_total - base !== 4) begin failures++; $display("FAIL ev_beats got=%0d exp=4", beat_total - base); end
    checks++; if (la[base[7:0]] !== 32'h000 || lw[base[7:0]] !== 32'h5 || ls[base[7:0]] !== 4'hF) begin
      failures++; $display("FAIL ev_wb0 got=%h/%h/%h exp=00000000/00000005/f", la[base[7:0]], lw[base[7:0]], ls[base[7:0]]); end
    checks++; if (la[8'(base + 1)] !== 32'h004 || lw[8'(base + 1)] !== 32'hC0DE0001 || ls[8'(base + 1)] !== 4'hF) begin
      failures++; $display("FAIL ev_wb1 got=%h/%h/%h exp=00000004/c0de0001/f", la[8'(base + 1)], lw[8'(base + 1)], ls[8'(base + 1)]); end
    checks++; if (la[8'(base + 2)] !== 32'h400 || la[8'(base + 3)] !== 32'h404 || ls[8'(base + 2)] !== 4'h0) begin
      failures++; $display("FAIL ev_fill got=%h/%h exp=00000400/00000404", la[8'(base + 2)], la[8'(base + 3)]); end
    checks++; if (rd !== 32'hC0DE0100) begin failures++; $display("FAIL ev_rdata got=%h exp=c0de0100", rd); end
    checks++; if (miss_count !== st(5)) begin failures++; $display("FAIL ev_miss got=%0d exp=%0d", miss_count, st(5)); end
    cpu_access(32'h200, 32'h0, 4'h0, rd, lat, base);
    checks++; if (beat_total - base !== 0 || lat !== 2) begin
      failures++; $display("FAIL ev_way1_kept beats=%0d lat=%0d exp=0/2", beat_total - base, lat); end
    cpu_access(32'h000, 32'h0, 4'h0, rd, lat, base);
    checks++; if (beat_total - base !== 2 || rd !== 32'h5) begin
      failures++; $display("FAIL ev_way0_gone beats=%0d rdata=%h exp=2/00000005", beat_total - base, rd); end
    checks++; if (hit_count !== st(4) || miss_count !== st(6)) begin
      failures++; $display("FAIL ev_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, st(4), st(6)); end
  endtask

  task automatic test_uncached();
    logic [31:0] rd; int lat, base;
    cpu_access(32'h1000_0000, 32'h41, 4'h1, rd, lat, base);
    checks++; if (beat_total - base !== 1) begin failures++; $display("FAIL unc_beats got=%0d exp=1", beat_total - base); end
    checks++; if (la[base[7:0]] !== 32'h1000_0000 || lw[base[7:0]] !== 32'h41 || ls[base[7:0]] !== 4'h1) begin
      failures++; $display("FAIL unc_beat got=%h/%h/%h exp=10000000/00000041/1", la[base[7:0]], lw[base[7:0]], ls[base[7:0]]); end
    checks++; if (hit_count !== st(4) || miss_count !== st(6)) begin
      failures++; $display("FAIL unc_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, st(4), st(6)); end
    cpu_access(32'h000, 32'h0, 4'h0, rd, lat, base);
    checks++; if (beat_total - base !== 0 || rd !== 32'h5 || hit_count !== st(5)) begin
      failures++; $display("FAIL unc_then_hit beats=%0d rdata=%h hits=%0d exp=0/00000005/%0d", beat_total - base, rd, hit_count, st(5)); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd; int lat, base; bit seen;
    @(negedge clk);
    cpu_addr = 32'h180; cpu_wdata = '0; cpu_wstrb = 4'h0; cpu_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL midfill_no_beat got=0 exp=1"); end
    resetn = 1'b0; cpu_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL midfill_mem_valid got=%b exp=0", mem_valid); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0 || cpu_ready !== 1'b0) begin
      failures++; $display("FAIL midfill_reset got=%0d/%0d/%b exp=0/0/0", hit_count, miss_count, cpu_ready); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    cpu_access(32'h180, 32'h0, 4'h0, rd, lat, base);
    checks++; if (beat_total - base !== 2 || la[base[7:0]] !== 32'h180 || la[8'(base + 1)] !== 32'h184) begin
      failures++; $display("FAIL midfill_refill beats=%0d a0=%h a1=%h exp=2/00000180/00000184", beat_total - base, la[base[7:0]], la[8'(base + 1)]); end
    checks++; if (rd !== 32'hC0DE0060) begin failures++; $display("FAIL midfill_rdata got=%h exp=c0de0060", rd); end
    checks++; if (hit_count !== st(0) || miss_count !== st(1)) begin
      failures++; $display("FAIL midfill_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, st(0), st(1)); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[10'h40] = 32'hAAAA_0000;
    mem[10'h41] = 32'hBBBB_0001;
    mem[10'h42] = 32'h1122_3344;
    mem_rdata = '0;
    mem_ready = 1'b0;
    test_reset();
    test_cold_read();
    test_byte_write();
    test_eviction();
    test_uncached();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
